// File: rtl/load_store_unit.sv
// Load/store initiator for the data-memory MMIO bus: steers byte lanes, builds byte
// masks, waits out the read latency and sign/zero-extends loads; flags misaligned requests.
module load_store_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        isStore,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] loadData,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic        memWrite,
  output logic [3:0]  byteMask,
  input  logic [31:0] memReadData
);

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LOAD_WAIT,
    LOAD_CAPTURE,
    DONE
  } state_t;

  localparam logic [1:0] CNT_LAST = 2'(READ_LATENCY - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;
  logic        mem_write_q, mem_write_d;
  logic [3:0]  byte_mask_q, byte_mask_d;

  logic        code_ok;
  logic        aligned;
  logic [3:0]  store_mask;
  logic [31:0] store_lanes;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;

  // Request decode, evaluated on the live inputs while IDLE.
  always_comb begin
    code_ok = isStore ? (funct3 inside {3'b000, 3'b001, 3'b010})
                      : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    aligned = 1'b0;
    store_mask = 4'b1111;
    store_lanes = storeData;
    case (funct3[1:0])
      2'b00: begin
        aligned = 1'b1;
        store_mask = 4'b0001 << address[1:0];
        store_lanes = {4{storeData[7:0]}};
      end
      2'b01: begin
        aligned = ~address[0];
        store_mask = 4'b0011 << address[1:0];
        store_lanes = {2{storeData[15:0]}};
      end
      2'b10: aligned = (address[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Lane selection and extension of the returned word, using the latched request.
  always_comb begin
    rd_byte = memReadData[7:0];
    case (addr_lo_q)
      2'b00: rd_byte = memReadData[7:0];
      2'b01: rd_byte = memReadData[15:8];
      2'b10: rd_byte = memReadData[23:16];
      default: rd_byte = memReadData[31:24];
    endcase
    rd_half = addr_lo_q[1] ? memReadData[31:16] : memReadData[15:0];
    case (funct3_q)
      3'b000: load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001: load_ext = {{16{rd_half[15]}}, rd_half};
      3'b100: load_ext = {24'h0, rd_byte};
      3'b101: load_ext = {16'h0, rd_half};
      default: load_ext = memReadData;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    funct3_d = funct3_q;
    addr_lo_d = addr_lo_q;
    busy_d = busy_q;
    done_d = 1'b0;
    fault_d = 1'b0;
    load_data_d = load_data_q;
    mem_address_d = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    mem_write_d = 1'b0;
    byte_mask_d = 4'b0000;
    case (state_q)
      IDLE: begin
        if (start) begin
          funct3_d = funct3;
          addr_lo_d = address[1:0];
          mem_address_d = {address[31:2], 2'b00};
          busy_d = 1'b1;
          if (!(code_ok && aligned)) begin
            state_d = DONE;
            done_d = 1'b1;
            fault_d = 1'b1;
          end else if (isStore) begin
            state_d = STORE;
            mem_write_d = 1'b1;
            byte_mask_d = store_mask;
            mem_write_data_d = store_lanes;
          end else begin
            state_d = LOAD_WAIT;
            cnt_d = 2'd0;
          end
        end
      end
      STORE: begin
        state_d = DONE;
        done_d = 1'b1;
      end
      LOAD_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = LOAD_CAPTURE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      LOAD_CAPTURE: begin
        load_data_d = load_ext;
        state_d = DONE;
        done_d = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q <= 2'd0;
      funct3_q <= 3'd0;
      addr_lo_q <= 2'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      fault_q <= 1'b0;
      load_data_q <= 32'h0;
      mem_address_q <= 32'h0;
      mem_write_data_q <= 32'h0;
      mem_write_q <= 1'b0;
      byte_mask_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      funct3_q <= funct3_d;
      addr_lo_q <= addr_lo_d;
      busy_q <= busy_d;
      done_q <= done_d;
      fault_q <= fault_d;
      load_data_q <= load_data_d;
      mem_address_q <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_write_q <= mem_write_d;
      byte_mask_q <= byte_mask_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign fault = fault_q;
  assign loadData = load_data_q;
  assign memAddress = mem_address_q;
  assign memWriteData = mem_write_data_q;
  assign memWrite = mem_write_q;
  assign byteMask = byte_mask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level reference memory, queued expectations,
// and a negedge monitor that checks every bus write and every done pulse.
module tb_load_store_unit;

  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        isStore = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] address = 32'h0;
  logic [31:0] storeData = 32'h0;
  logic        busy, done, fault, memWrite;
  logic [31:0] loadData, memAddress, memWriteData, memReadData;
  logic [3:0]  byteMask;

  load_store_unit #(.READ_LATENCY(RL)) dut (
    .clk(clk), .resetn(resetn), .start(start), .isStore(isStore), .funct3(funct3),
    .address(address), .storeData(storeData), .busy(busy), .done(done), .fault(fault),
    .loadData(loadData), .memAddress(memAddress), .memWriteData(memWriteData),
    .memWrite(memWrite), .byteMask(byteMask), .memReadData(memReadData)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read responder with RL cycles of latency.
  logic        mem_clear = 1'b1;
  logic [31:0] resp_mem [16];
  logic [31:0] rd_pipe [RL];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) resp_mem[i] <= 32'h0;
    end else if (memWrite) begin
      for (int b = 0; b < 4; b++)
        if (byteMask[b]) resp_mem[memAddress[5:2]][b*8 +: 8] <= memWriteData[b*8 +: 8];
    end
    rd_pipe[0] <= resp_mem[memAddress[5:2]];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign memReadData = rd_pipe[RL-1];

  typedef struct {
    int          done_cyc;
    logic        fault;
    logic [31:0] load_data;
    logic [31:0] mem_addr;
  } exp_t;
  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  exp_t mon_e;
  wr_t  mon_w;
  int   tests = 0;
  int   fails = 0;
  byte unsigned ref_mem [64];
  logic [31:0] ref_load = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every write and every done must match the head of its queue.
  always @(negedge clk) begin
    if (resetn) begin
      if (memWrite) begin
        if (wr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got write at cycle %0d expected none", cyc);
        end else begin
          mon_w = wr_q.pop_front();
          chk("wr_cycle", 32'(cyc), 32'(mon_w.cyc));
          chk("wr_addr", memAddress, mon_w.addr);
          chk("wr_mask", {28'h0, byteMask}, {28'h0, mon_w.mask});
          chk("wr_data", memWriteData, mon_w.data);
        end
      end else begin
        chk("mask_idle", {28'h0, byteMask}, 32'h0);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
          chk("fault", {31'h0, fault}, {31'h0, mon_e.fault});
          chk("load_data", loadData, mon_e.load_data);
          chk("mem_addr", memAddress, mon_e.mem_addr);
          chk("busy_at_done", {31'h0, busy}, 32'h1);
          chk("wr_pending", 32'(wr_q.size()), 32'h0);
        end
      end
    end
  end

  function automatic int nbytes_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic ref_legal(input logic st, input logic [2:0] f3, input logic [31:0] a);
    if (st && f3 > 3'd2) return 1'b0;
    if (!st && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    return (a % nbytes_of(f3)) == 0;
  endfunction

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input int hold);
    int c, k, n, lo;
    longint v;
    logic legal;
    exp_t e;
    wr_t w;
    @(negedge clk);
    c = cyc;
    legal = ref_legal(st, f3, a);
    n = nbytes_of(f3);
    lo = int'(a % 4);
    if (!legal) k = 1;
    else if (st) k = 2;
    else k = 2 + RL;
    if (legal && !st) begin
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(ref_mem[int'(a) + i]) << (8 * i);
      if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
      ref_load = v[31:0];
    end
    if (legal && st) begin
      w.cyc = c + 1;
      w.addr = a & ~32'h3;
      for (int j = 0; j < 4; j++) begin
        w.mask[j] = (j >= lo) && (j < lo + n);
        w.data[8*j +: 8] = sd[8*(j % n) +: 8];
      end
      for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = sd[8*i +: 8];
      wr_q.push_back(w);
    end
    e.done_cyc = c + k;
    e.fault = !legal;
    e.load_data = ref_load;
    e.mem_addr = a & ~32'h3;
    exp_q.push_back(e);
    start = 1'b1; isStore = st; funct3 = f3; address = a; storeData = sd;
    repeat (hold) @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && (busy || done); i++) @(negedge clk);
    if (busy || done) begin
      tests++; fails++;
      $display("FAIL timeout: got busy=%0b done=%0b expected idle", busy, done);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] f3r;
    logic [31:0] ar;
    logic str;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_memwrite", {31'h0, memWrite}, 32'h0);
    chk("rst_mask", {28'h0, byteMask}, 32'h0);
    chk("rst_loaddata", loadData, 32'h0);
    chk("rst_memaddr", memAddress, 32'h0);
    chk("rst_wdata", memWriteData, 32'h0);
    resetn = 1'b1;
    mem_clear = 1'b0;
    repeat (RL + 1) @(negedge clk);

    issue(1'b1, 3'b010, 32'h0, 32'hDEADBEEF, 1);
    issue(1'b1, 3'b000, 32'h5, 32'h12345680, 1);
    issue(1'b1, 3'b001, 32'h6, 32'h0000BEEF, 1);
    issue(1'b0, 3'b000, 32'h5, 32'h0, 1);
    chk("lb_0x5", loadData, 32'hFFFFFF80);
    issue(1'b0, 3'b100, 32'h5, 32'h0, 1);
    chk("lbu_0x5", loadData, 32'h00000080);
    issue(1'b0, 3'b001, 32'h6, 32'h0, 1);
    chk("lh_0x6", loadData, 32'hFFFFBEEF);
    issue(1'b0, 3'b101, 32'h6, 32'h0, 1);
    chk("lhu_0x6", loadData, 32'h0000BEEF);
    issue(1'b0, 3'b010, 32'h4, 32'h0, 1);
    chk("lw_0x4", loadData, 32'hBEEF8000);
    issue(1'b0, 3'b001, 32'h3, 32'h0, 1);
    issue(1'b1, 3'b010, 32'h2, 32'hCAFEF00D, 1);
    issue(1'b0, 3'b011, 32'h0, 32'h0, 1);
    chk("fault_keeps_load", loadData, 32'hBEEF8000);

    // start held high while busy must not launch a second write
    issue(1'b1, 3'b010, 32'h8, 32'h11223344, 3);
    issue(1'b0, 3'b010, 32'h8, 32'h0, 1);
    chk("lw_0x8", loadData, 32'h11223344);

    // reset during LOAD_WAIT abandons the request
    issue(1'b0, 3'b010, 32'h4, 32'h0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_done", {31'h0, done}, 32'h0);
    chk("mid_rst_memwrite", {31'h0, memWrite}, 32'h0);
    chk("mid_rst_loaddata", loadData, 32'h0);
    exp_q.delete();
    ref_load = 32'h0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    issue(1'b0, 3'b010, 32'h4, 32'h0, 1);
    chk("lw_after_rst", loadData, 32'hBEEF8000);

    for (int t = 0; t < 150; t++) begin
      str = 1'($urandom_range(0, 1));
      f3r = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        if (str) f3r = 3'($urandom_range(0, 2));
        else begin
          case ($urandom_range(0, 4))
            0: f3r = 3'd0;
            1: f3r = 3'd1;
            2: f3r = 3'd2;
            3: f3r = 3'd4;
            default: f3r = 3'd5;
          endcase
        end
      end
      ar = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (f3r[1:0] == 2'b01) ar = ar & ~32'h1;
        else if (f3r[1:0] == 2'b10) ar = ar & ~32'h3;
      end
      issue(str, f3r, ar, $urandom, 1);
    end

    repeat (4) @(negedge clk);
    chk("exp_drained", 32'(exp_q.size()), 32'h0);
    chk("wr_drained", 32'(wr_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
